bw2gray_unpack: RTL and testbench
=================================

Name: bw2gray_unpack

Overview:
- Inverse of the grayscale-to-black/white thresholding stage: accepts packed 1-bit-per-pixel black/white bytes (8 pixels per byte, MSB first) and emits one 8-bit grayscale pixel per accepted output beat.
- A pixel value of 1 maps to a programmable white level; a value of 0 maps to a programmable black level.
- Tracks position within an image line, drops pad bits in the final byte of a line, and flags the last pixel of each line.
- Sits between the packed binary image buffer and the gray-domain display/output path; valid/ready on both sides.

Parameters:
- LINE_W, 640, pixels per image line (1..4095); need not be a multiple of 8.
- CW, 12, width of the line pixel counter; must satisfy 2^CW > LINE_W.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- en_i  in  1  global enable; low freezes all state.
- veri_i  in  8  packed BW byte; bit7 is the first pixel.
- veri_valid_i  in  1  input byte valid.
- veri_ready_o  out  1  block can accept a byte this cycle.
- beyaz_degeri  in  8  gray level for pixel=1; captured with each accepted byte.
- siyah_degeri  in  8  gray level for pixel=0; captured with each accepted byte.
- veri_o  out  8  gray pixel.
- veri_valid_o  out  1  veri_o valid.
- veri_ready_i  in  1  downstream accepts veri_o.
- satir_son_o  out  1  veri_o is pixel LINE_W-1 of the line; qualified by veri_valid_o.

Behaviour:
- Reset (rst_i=0, asynchronous): state BOS, shift register 0, bit count 0, line counter 0, veri_o=0, veri_valid_o=0, satir_son_o=0, veri_ready_o=0 while reset is asserted. Reset mid-line discards any held byte.
- States:
  - BOS (empty): veri_ready_o = en_i.
  - DOLU (holding a byte with bits remaining).
- Accept: the input handshake completes when veri_valid_i && veri_ready_o. On accept, latch veri_i, beyaz_degeri and siyah_degeri, and set kalan = min(8, LINE_W - line counter).
- Output pixel register: veri_o = current MSB ? beyaz : siyah. veri_valid_o=1 in DOLU.
- Latency: byte accepted at edge N gives the first pixel on veri_o after edge N (visible in cycle N+1).
- Output advance: when veri_valid_o && veri_ready_i:
  - shift left by one, decrement kalan, increment the line counter;
  - when the line counter reaches LINE_W-1 and is consumed, wrap it to 0.
- satir_son_o=1 exactly when the presented pixel's line index equals LINE_W-1.
- Pad bits: when a line ends mid-byte, the remaining bits of that byte are discarded. The next byte starts the new line at its bit7.
- Back-to-back: in DOLU with kalan==1 and the output being consumed, veri_ready_o = en_i. A byte accepted in that same cycle is presented on the next cycle with no bubble. Sustained throughput is 1 pixel/clock.
- Otherwise veri_ready_o=0 in DOLU. If the last pixel is consumed and no byte is accepted, go to BOS and set veri_valid_o=0.
- Stall: veri_ready_i=0 holds veri_o, satir_son_o and veri_valid_o stable. Once asserted, veri_valid_o never drops without a handshake.
- en_i=0: all registers hold; veri_ready_o=0. Outputs keep their present values, but no output handshake counts while en_i=0, even if veri_ready_i=1.
- Level change: the levels only take effect at byte acceptance. Changing beyaz_degeri or siyah_degeri mid-byte does not affect pixels already held.

Decomposition:
- Shared package (img_pkg):
  - PIX_W=8;
  - WORD_PIX=8;
  - state enum {BOS, DOLU};
  - default levels BEYAZ=8'hFF, SIYAH=8'h00.
- One natural sub-module: bw_line_counter. It is a CW-bit counter with an advance input, wrap at LINE_W-1, a last flag, and a "remaining in line" output used for the kalan computation.
- The shift/handshake FSM stays in the top module.

Test Plan:
- Reset then byte 8'hA5, levels FF/00, veri_ready_i=1 → veri_o sequence FF,00,FF,00,00,FF,00,FF on 8 consecutive cycles, starting the cycle after accept.
- Two bytes 8'hFF, 8'h00 offered back-to-back, ready=1 → 16 contiguous valid cycles (8×FF then 8×00). veri_ready_o is high in the kalan==1 cycle.
- LINE_W=10, bytes 8'hFF, 8'hFF, 8'h80 → 10 pixels of FF with satir_son_o on the 10th. The 6 pad bits are dropped. The next line's first pixel comes from 8'h80 bit7 = FF, followed by 00s.
- Levels beyaz=8'hC8, siyah=8'h32 captured, then changed to 8'h11 after accept, byte 8'hF0 → C8×4, 32×4; the new level appears only on the next byte.
- veri_ready_i toggled 0/1 every cycle plus en_i=0 for 3 cycles mid-byte → no pixel lost or duplicated, veri_o stable during stalls, 8 outputs total.
- rst_i pulsed low asynchronously mid-byte (between edges) → veri_valid_o=0 immediately. After release, the next byte starts at line index 0.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the gray/black-white image path.
package img_pkg;

  localparam int PIX_W    = 8;
  localparam int WORD_PIX = 8;
  localparam int KW       = $clog2(WORD_PIX + 1);

  typedef enum logic {
    BOS  = 1'b0,
    DOLU = 1'b1
  } state_t;

  localparam logic [PIX_W-1:0] BEYAZ = 8'hFF;
  localparam logic [PIX_W-1:0] SIYAH = 8'h00;

  // Pixels to take from a byte: a full word, or only what is left of the line.
  function automatic logic [KW-1:0] kalan_min(input int unsigned rem);
    if (rem >= WORD_PIX) return KW'(WORD_PIX);
    return KW'(rem);
  endfunction

endpackage

// File: rtl/bw_line_counter.sv
// Pixel position within an image line; wraps after LINE_W-1 and reports the
// pixels left in the line as they will stand after this cycle's advance.
module bw_line_counter #(
  parameter int LINE_W = 640,
  parameter int CW     = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  output logic          last_o,
  output logic [CW-1:0] rem_o
);

  logic [CW-1:0] cnt_q;

  assign last_o = (cnt_q == CW'(LINE_W - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      cnt_q <= '0;
    else if (adv_i)  cnt_q <= last_o ? '0 : cnt_q + CW'(1);
  end

  // A byte accepted while the last pixel of a line drains starts a fresh line.
  always_comb begin
    rem_o = CW'(LINE_W) - cnt_q;
    if (adv_i) rem_o = last_o ? CW'(LINE_W) : CW'(LINE_W - 1) - cnt_q;
  end

endmodule

// File: rtl/bw2gray_unpack.sv
// Unpacks 1-bit-per-pixel black/white bytes (MSB first) into 8-bit gray pixels,
// dropping pad bits at line ends and flagging the last pixel of each line.
module bw2gray_unpack
  import img_pkg::*;
#(
  parameter int LINE_W = 640,
  parameter int CW     = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] veri_i,
  input  logic       veri_valid_i,
  output logic       veri_ready_o,
  input  logic [7:0] beyaz_degeri,
  input  logic [7:0] siyah_degeri,
  output logic [7:0] veri_o,
  output logic       veri_valid_o,
  input  logic       veri_ready_i,
  output logic       satir_son_o
);

  state_t               state_p0, state_nxt;
  logic [WORD_PIX-1:0]  sr_p0;
  logic [KW-1:0]        kalan_p0;
  logic [PIX_W-1:0]     beyaz_p0, siyah_p0;

  logic                 acc, adv, kalan_bir, line_last;
  logic [CW-1:0]        line_rem;

  assign kalan_bir = (kalan_p0 == KW'(1));
  assign adv       = en_i && (state_p0 == DOLU) && veri_ready_i;
  assign acc       = veri_valid_i && veri_ready_o;

  bw_line_counter #(
    .LINE_W (LINE_W),
    .CW     (CW)
  ) u_line_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adv_i  (adv),
    .last_o (line_last),
    .rem_o  (line_rem)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_p0 <= BOS;
    else        state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      BOS:     if (acc) state_nxt = DOLU;
      DOLU:    if (adv && kalan_bir && !acc) state_nxt = BOS;
      default: state_nxt = BOS;
    endcase
  end

  // Held byte: a new byte overrides the shift so a refill is bubble-free.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sr_p0    <= '0;
      kalan_p0 <= '0;
      beyaz_p0 <= BEYAZ;
      siyah_p0 <= SIYAH;
    end else if (acc) begin
      sr_p0    <= veri_i;
      kalan_p0 <= kalan_min(32'(line_rem));
      beyaz_p0 <= beyaz_degeri;
      siyah_p0 <= siyah_degeri;
    end else if (adv) begin
      sr_p0    <= {sr_p0[WORD_PIX-2:0], 1'b0};
      kalan_p0 <= kalan_p0 - KW'(1);
    end
  end

  always_comb begin
    veri_ready_o = 1'b0;
    if (rst_i && en_i) begin
      case (state_p0)
        BOS:     veri_ready_o = 1'b1;
        DOLU:    veri_ready_o = kalan_bir && veri_ready_i;
        default: veri_ready_o = 1'b0;
      endcase
    end
    veri_valid_o = (state_p0 == DOLU);
    satir_son_o  = (state_p0 == DOLU) && line_last;
    veri_o       = sr_p0[WORD_PIX-1] ? beyaz_p0 : siyah_p0;
  end

endmodule

// File: tb/tb_bw2gray_unpack.sv
// Directed scoreboard bench for bw2gray_unpack: a long-line and a 10-pixel-line instance.
module tb_bw2gray_unpack;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, vin, rdy, sel;
  logic [7:0] din, bey, siy;
  logic       vin_a, vin_b;
  logic       rdy_a, vld_a, last_a, rdy_b, vld_b, last_b;
  logic [7:0] dout_a, dout_b;
  logic       obs_rdy, obs_vld, obs_last;
  logic [7:0] obs_pix;

  assign vin_a    = vin & ~sel;
  assign vin_b    = vin & sel;
  assign obs_rdy  = sel ? rdy_b  : rdy_a;
  assign obs_vld  = sel ? vld_b  : vld_a;
  assign obs_last = sel ? last_b : last_a;
  assign obs_pix  = sel ? dout_b : dout_a;

  bw2gray_unpack #(.LINE_W(640), .CW(12)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .veri_i(din), .veri_valid_i(vin_a),
    .veri_ready_o(rdy_a), .beyaz_degeri(bey), .siyah_degeri(siy), .veri_o(dout_a),
    .veri_valid_o(vld_a), .veri_ready_i(rdy), .satir_son_o(last_a)
  );

  bw2gray_unpack #(.LINE_W(10), .CW(4)) u_dut10 (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .veri_i(din), .veri_valid_i(vin_b),
    .veri_ready_o(rdy_b), .beyaz_degeri(bey), .siyah_degeri(siy), .veri_o(dout_b),
    .veri_valid_o(vld_b), .veri_ready_i(rdy), .satir_son_o(last_b)
  );

  logic [8:0] exp_q[$];
  int         pidx[2];
  int         n_chk, n_pass, hs_cnt, acc_at;
  logic       prev_hold;
  logic [8:0] prev_out;
  bit         acc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int lw, n;
    lw = sel ? 10 : 640;
    n  = (lw - pidx[sel] < 8) ? lw - pidx[sel] : 8;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({pidx[sel] == lw - 1, b[7-k] ? bey : siy});
      pidx[sel] = (pidx[sel] == lw - 1) ? 0 : pidx[sel] + 1;
    end
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick(output bit accepted);
    logic [8:0] e;
    bit hs_out;
    #1;
    if (prev_hold) begin
      chk("stall_valid", 16'(obs_vld), 16'd1);
      chk("stall_hold", 16'({obs_last, obs_pix}), 16'(prev_out));
    end
    hs_out = obs_vld && rdy && en;
    if (hs_out) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("extra_pixel", 16'({obs_last, obs_pix}), 16'hDEAD);
      else begin
        e = exp_q.pop_front();
        chk("pixel", 16'({obs_last, obs_pix}), 16'(e));
      end
    end
    prev_hold = obs_vld && !hs_out;
    prev_out  = {obs_last, obs_pix};
    accepted  = vin && obs_rdy;
    if (accepted) push_byte(din);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit a;
    a   = 1'b0;
    vin = 1'b1;
    din = b;
    for (int i = 0; i < 50 && !a; i++) tick(a);
    vin = 1'b0;
    if (!a) begin
      n_chk++;
      $error("FAIL accept_timeout observed=no accept expected=accept within 50 cycles");
    end
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || obs_vld); i++) tick(a);
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    chk("drain_idle", 16'(obs_vld), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=simulation still running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; hs_cnt = 0; acc_at = -1;
    prev_hold = 1'b0; prev_out = '0; pidx[0] = 0; pidx[1] = 0;
    rst_n = 1'b0; en = 1'b1; vin = 1'b0; rdy = 1'b1; sel = 1'b0;
    din = 8'h00; bey = 8'hFF; siy = 8'h00;

    // reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", 16'(vld_a), 16'd0);
    chk("rst_pix", 16'(dout_a), 16'd0);
    chk("rst_last", 16'(last_a), 16'd0);
    chk("rst_ready_a", 16'(rdy_a), 16'd0);
    chk("rst_ready_b", 16'(rdy_b), 16'd0);
    rst_n = 1'b1; #1;
    chk("idle_ready", 16'(rdy_a), 16'd1);
    @(negedge clk);

    // single byte A5, one pixel per cycle starting right after accept
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) begin
      #1 chk("t1_valid", 16'(obs_vld), 16'd1);
      tick(acc);
    end
    drain();

    // back-to-back FF then 00 with no bubble
    vin = 1'b1; din = 8'hFF;
    tick(acc);
    chk("t2_first_accept", 16'(acc), 16'd1);
    din = 8'h00;
    for (int i = 0; i < 16; i++) begin
      #1 chk("t2_valid", 16'(obs_vld), 16'd1);
      tick(acc);
      if (acc) begin acc_at = i; vin = 1'b0; end
    end
    vin = 1'b0;
    chk("t2_accept_cycle", 16'(acc_at), 16'd7);
    drain();

    // 10-pixel line: pad bits dropped, last flag on pixel 9
    sel = 1'b1;
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h80);
    drain();
    sel = 1'b0;

    // levels captured at accept; later changes affect only the next byte
    bey = 8'hC8; siy = 8'h32;
    send_byte(8'hF0);
    bey = 8'h11; siy = 8'h11;
    send_byte(8'hF0);
    drain();
    bey = 8'hFF; siy = 8'h00;

    // ready toggling plus a 3-cycle enable drop mid-byte
    send_byte(8'h3C);
    hs_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      rdy = i[0];
      en  = !(i >= 4 && i < 7);
      tick(acc);
    end
    rdy = 1'b1; en = 1'b1;
    chk("t5_count", 16'(hs_cnt), 16'd8);
    drain();

    // asynchronous reset mid-byte, mid-line on the short-line instance
    sel = 1'b1;
    send_byte(8'hFF);
    tick(acc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(vld_b), 16'd0);
    chk("arst_pix", 16'(dout_b), 16'd0);
    chk("arst_last", 16'(last_b), 16'd0);
    chk("arst_ready", 16'(rdy_b), 16'd0);
    exp_q.delete();
    prev_hold = 1'b0; pidx[0] = 0; pidx[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hFF);
    send_byte(8'hC0);
    drain();
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
